// File: rtl/decoder_pkg.sv
// Shared types and constants for the pipelined one-hot decoder.
package decoder_pkg;

    localparam int default_width = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } fifo_state_e;

endpackage

// File: rtl/fifo2.sv
// Two-entry in-order buffer for decoded words; head entry always drives the output.
module fifo2
    import decoder_pkg::*;
#(
    parameter int width = default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [width-1:0] push_data,
    input  logic             push_err,
    output fifo_state_e      state,
    output logic [width-1:0] head_data,
    output logic             head_err
);

    fifo_state_e      state_q, state_d;
    logic             load_head, load_tail, shift;
    logic [width-1:0] tail_data;
    logic             tail_err;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        load_head = 1'b0;
        load_tail = 1'b0;
        shift     = 1'b0;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d   = ONE;
                    load_head = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head = 1'b1;
                end else if (push) begin
                    state_d   = FULL;
                    load_tail = 1'b1;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    shift   = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            // NOTE: storage is cleared on reset so a dropped word can never reappear on the output.
            head_data <= '0;
            head_err  <= 1'b0;
            tail_data <= '0;
            tail_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_head) begin
                head_data <= push_data;
                head_err  <= push_err;
            end else if (shift) begin
                head_data <= tail_data;
                head_err  <= tail_err;
            end
            if (load_tail) begin
                tail_data <= push_data;
                tail_err  <= push_err;
            end
        end
    end

    assign state = state_q;

endmodule

// File: rtl/decoder3_to_8_pipe.sv
// Binary-to-one-hot decoder with valid/ready handshakes, a 2-entry output buffer
// and a saturating count of error-free words delivered.
module decoder3_to_8_pipe
    import decoder_pkg::*;
#(
    parameter int width = default_width
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(width)-1:0] in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [width-1:0]         out,
    output logic                     err,
    output logic [15:0]              count
);

    fifo_state_e      state;
    logic             push, pop;
    logic [width-1:0] dec_data;
    logic             dec_err;

    // Codes at or above width only exist when width is not a power of two.
    always_comb begin
        dec_data = '0;
        dec_err  = 1'b0;
        if (int'(in) < width) begin
            dec_data = {{(width-1){1'b0}}, 1'b1} << in;
        end else begin
            dec_err = 1'b1;
        end
    end

    assign in_ready  = (state != FULL) && !rst;
    assign out_valid = (state != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    fifo2 #(.width(width)) u_fifo2 (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .push_data (dec_data),
        .push_err  (dec_err),
        .state     (state),
        .head_data (out),
        .head_err  (err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (pop && !err && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: tb/tb_decoder3_to_8_pipe.sv
// Self-checking bench: width=8 and width=6 decoders driven in lockstep, checked
// against explicit vectors and a queue-based reference model of the width=8 instance.
module tb_decoder3_to_8_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_code = 3'd0;
    logic       out_ready = 1'b0;

    logic        in_ready8, out_valid8, err8;
    logic [7:0]  out8;
    logic [15:0] count8;
    logic        in_ready6, out_valid6, err6;
    logic [5:0]  out6;
    logic [15:0] count6;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    decoder3_to_8_pipe #(.width(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in(in_code),
        .out_valid(out_valid8), .out_ready(out_ready), .out(out8), .err(err8), .count(count8)
    );

    decoder3_to_8_pipe #(.width(6)) dut6 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6), .in(in_code),
        .out_valid(out_valid6), .out_ready(out_ready), .out(out6), .err(err6), .count(count6)
    );

    typedef struct {
        logic [7:0] data;
        logic       err;
    } word_t;

    typedef struct {
        logic [2:0] code;
        logic [7:0] exp8;
        logic [5:0] exp6;
        logic       err6;
    } vec_t;

    word_t       q[$];
    int unsigned mcount = 0;
    bit          chk_en = 1'b1;
    vec_t        vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One rising edge; the reference model advances with it, then the width=8 DUT is compared.
    task automatic cycle();
        bit    p, o;
        word_t w;
        p = in_valid && !rst && (q.size() < 2);
        o = !rst && (q.size() > 0) && out_ready;
        w.data = 8'(2 ** int'(in_code));
        w.err  = 1'b0;
        @(posedge clk);
        if (rst) begin
            q.delete();
            mcount = 0;
        end else begin
            if (o) begin
                if (!q[0].err && mcount < 65535) mcount++;
                void'(q.pop_front());
            end
            if (p) q.push_back(w);
        end
        #1;
        if (chk_en) begin
            check("sb_out_valid", 32'(out_valid8), 32'(q.size() > 0));
            if (q.size() > 0) begin
                check("sb_out", 32'(out8), 32'(q[0].data));
                check("sb_err", 32'(err8), 32'(q[0].err));
            end
            check("sb_in_ready", 32'(in_ready8), 32'((q.size() < 2) && !rst));
            check("sb_count", 32'(count8), mcount);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] c6;

        vecs[0] = '{3'd0, 8'h01, 6'h01, 1'b0};
        vecs[1] = '{3'd1, 8'h02, 6'h02, 1'b0};
        vecs[2] = '{3'd2, 8'h04, 6'h04, 1'b0};
        vecs[3] = '{3'd3, 8'h08, 6'h08, 1'b0};
        vecs[4] = '{3'd4, 8'h10, 6'h10, 1'b0};
        vecs[5] = '{3'd5, 8'h20, 6'h20, 1'b0};
        vecs[6] = '{3'd6, 8'h40, 6'h00, 1'b1};
        vecs[7] = '{3'd7, 8'h80, 6'h00, 1'b1};

        // Reset state, with rst held across two edges.
        cycle();
        cycle();
        check("rst_in_ready8", 32'(in_ready8), 32'd0);
        check("rst_in_ready6", 32'(in_ready6), 32'd0);
        check("rst_out8", 32'(out8), 32'd0);
        check("rst_err8", 32'(err8), 32'd0);
        check("rst_count6", 32'(count6), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_release_in_ready", 32'(in_ready8), 32'd1);

        // Single decode of code 5.
        in_valid = 1'b1; in_code = 3'd5; out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        check("single_out_valid", 32'(out_valid8), 32'd1);
        check("single_out", 32'(out8), 32'h20);
        check("single_err", 32'(err8), 32'd0);
        cycle();
        check("single_count", 32'(count8), 32'd1);
        check("single_drained", 32'(out_valid8), 32'd0);

        // Table of every code on both widths.
        foreach (vecs[i]) begin
            in_valid = 1'b1; in_code = vecs[i].code; out_ready = 1'b1;
            cycle();
            in_valid = 1'b0;
            check($sformatf("vec%0d_out8", i), 32'(out8), 32'(vecs[i].exp8));
            check($sformatf("vec%0d_out6", i), 32'(out6), 32'(vecs[i].exp6));
            check($sformatf("vec%0d_err6", i), 32'(err6), 32'(vecs[i].err6));
            check($sformatf("vec%0d_valid6", i), 32'(out_valid6), 32'd1);
            cycle();
        end
        check("table_count8", 32'(count8), 32'd9);
        check("table_count6", 32'(count6), 32'd7);

        // Backpressure: fill, ignore a third push, then drain in order.
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 3'd3;
        cycle();
        in_code = 3'd6;
        cycle();
        check("bp_full_in_ready", 32'(in_ready8), 32'd0);
        check("bp_full_out", 32'(out8), 32'h08);
        in_code = 3'd1;
        cycle();
        check("bp_ignored_out", 32'(out8), 32'h08);
        check("bp_ignored_in_ready", 32'(in_ready8), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        check("bp_head", 32'(out8), 32'h08);
        cycle();
        check("bp_second", 32'(out8), 32'h40);
        check("bp_second_valid", 32'(out_valid8), 32'd1);
        cycle();
        check("bp_empty", 32'(out_valid8), 32'd0);

        // Out-of-range code on the width=6 instance.
        c6 = count6;
        in_valid = 1'b1; in_code = 3'd7; out_ready = 1'b0;
        cycle();
        in_valid = 1'b0;
        check("oor_out6", 32'(out6), 32'd0);
        check("oor_err6", 32'(err6), 32'd1);
        out_ready = 1'b1;
        cycle();
        check("oor_count6", 32'(count6), 32'(c6));
        check("oor_popped", 32'(out_valid6), 32'd0);

        // Streaming 50 random codes with push and pop in the same cycle.
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            in_code = 3'($urandom_range(7));
            #1;
            check("stream_in_ready", 32'(in_ready8), 32'd1);
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        check("stream_count", 32'(count8), 32'd50);

        // Reset while FULL drops both words.
        out_ready = 1'b0; in_valid = 1'b1;
        in_code = 3'd2; cycle();
        in_code = 3'd4; cycle();
        check("midrst_full", 32'(in_ready8), 32'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid8), 32'd0);
        check("midrst_out", 32'(out8), 32'd0);
        check("midrst_count", 32'(count8), 32'd0);
        check("midrst_in_ready", 32'(in_ready8), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("midrst_no_stale", 32'(out_valid8), 32'd0);
        end

        // Random traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(1));
            out_ready = 1'($urandom_range(1));
            in_code   = 3'($urandom_range(7));
            cycle();
        end

        // Saturation: 65538 error-free pops must stop at 16'hFFFF.
        do_reset();
        chk_en = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 65538; i++) begin
            in_code = 3'($urandom_range(7));
            cycle();
        end
        in_valid = 1'b0;
        cycle();
        chk_en = 1'b1;
        check("sat_model", mcount, 32'd65535);
        check("sat_count", 32'(count8), 32'hFFFF);
        in_valid = 1'b1; in_code = 3'd0;
        cycle();
        in_valid = 1'b0;
        cycle();
        check("sat_hold", 32'(count8), 32'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decoder3_to_8_pipe.md
DECODER3_TO_8_PIPE -- requirements
Module: decoder3_to_8_pipe

Interface
REQ-001 SHALL have parameter width, default 8, meaning the number of one-hot output bits; the code width is $clog2(width).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all logic samples on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port in_valid, input, 1 bit: the input code is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept a code this cycle.
REQ-006 SHALL have port in, input, $clog2(width) bits: binary code to decode.
REQ-007 SHALL have port out_valid, output, 1 bit: out/err hold a decoded word.
REQ-008 SHALL have port out_ready, input, 1 bit: the consumer accepts the word.
REQ-009 SHALL have port out, output, width bits: one-hot decode of the code.
REQ-010 SHALL have port err, output, 1 bit: the code was out of range (code >= width).
REQ-011 SHALL have port count, output, 16 bits: number of error-free words consumed.

Function
REQ-012 SHALL accept a code when in_valid && in_ready is true at a rising edge (a push).
REQ-013 SHALL complete an output transfer when out_valid && out_ready is true at a rising edge (a pop).
REQ-014 SHALL decode an in-range code k to out = 1<<k with err=0.
REQ-015 SHALL decode a code >= width (possible only when width is not a power of 2) to out=0 with err=1.
REQ-016 SHALL buffer decoded words in a 2-entry in-order FIFO; the FSM states are EMPTY, ONE and FULL.
REQ-017 SHALL make these FSM transitions:
- EMPTY: push -> ONE.
- ONE: push without pop -> FULL; pop without push -> EMPTY; push and pop together -> ONE.
- FULL: pop -> ONE.
REQ-018 SHALL drive in_ready = (state != FULL) && !rst, combinationally; no push is possible while FULL.
REQ-019 SHALL assert out_valid in the cycle after a push into EMPTY (latency 1); out_valid = (state != EMPTY).
REQ-020 SHALL hold out and err stable while out_valid && !out_ready.
REQ-021 SHALL present the FULL second entry on out in the cycle after the head entry is popped.
REQ-022 SHALL increment count on each pop with err=0, saturating at 16'hFFFF; pops with err=1 leave count unchanged.
REQ-023 SHALL drop in-flight words when reset is asserted mid-operation, with no partial output.

Reset
REQ-024 SHALL, at a rising edge with rst=1, set state=EMPTY, out_valid=0, out=0, err=0, count=0 and clear both FIFO entries.
REQ-025 SHALL hold in_ready=0 while rst=1 and raise it to 1 in the first cycle after rst is deasserted.

Structure
REQ-026 SHALL place the state enum (EMPTY/ONE/FULL) and the default width constant in the package decoder_pkg.
REQ-027 SHALL implement the 2-entry buffer as the sub-module fifo2 (data and err storage, occupancy FSM); the one-hot decode stays in the top module.

Verification
REQ-028 SHALL cover single decode (width=8): push in=5 into EMPTY, out_ready=1 -> next cycle out_valid=1, out=8'b0010_0000, err=0; count=1 after the pop.
REQ-029 SHALL cover backpressure: out_ready=0, push 3 then 6 -> state FULL, in_ready=0, out=8'h08 held; a third push with in_valid=1 is ignored; raise out_ready -> out=8'h08, then 8'h40, then out_valid=0.
REQ-030 SHALL cover simultaneous push and pop in ONE: stream 50 random codes with in_valid=1 and out_ready=1 -> every out equals 1<<code, in order, with in_ready=1 throughout; count=50.
REQ-031 SHALL cover out of range: width=6, push in=7 -> out=6'b0, err=1; count unchanged after the pop.
REQ-032 SHALL cover reset mid-operation: in FULL, assert rst for 1 cycle -> next cycle out_valid=0, out=0, count=0, in_ready=1; old words are never presented.
REQ-033 SHALL cover saturation: force 65537 error-free pops -> count=16'hFFFF, with no wrap to 0.
